mem_list_engine: RTL and testbench

- Initiator-side master for the 16-bit word memory (byte-addressed, big-endian word at address/address+1, combinational read, write on clock edge).
- Runs one of two list operations on a count-prefixed word list, such as neighborCount 0x68A with qValue base 0x1C8, or knownSinkCount 0x688 with knownSinks base 0x8:
  - READ: stream all entries out over a valid/ready port.
  - APPEND: write one entry, then increment the count word.
- Sits between the routing/learning FSMs and the memory, replacing ad-hoc address sequencing in each client.

---
 rtl/mem_list_engine.sv | 174 +++++++++++++++++
 tb/tb_mem_list_engine.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_list_engine.sv
// rtl/mem_list_engine.sv - count-prefixed word list master (READ streams entries, APPEND writes entry then count)
module mem_list_engine #(
  parameter int MAX_ENTRIES = 64,
  parameter int IDX_WIDTH   = 7
) (
  input  logic        clock,
  input  logic        nrst,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] base_addr,
  input  logic [15:0] count_addr,
  input  logic [15:0] app_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [15:0] mem_address,
  output logic        mem_wr_en,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_CNT, S_RD_ENT, S_WAIT_ACK, S_WR_ENT, S_WR_CNT, S_DONE
  } state_t;

  localparam logic [15:0] MAX_CNT = 16'(MAX_ENTRIES);

  state_t               state_q, state_d;
  logic                 op_q, op_d;
  logic [15:0]          base_q, base_d;
  logic [15:0]          caddr_q, caddr_d;
  logic [15:0]          app_q, app_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [15:0]          out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic                 err_q, err_d;

  logic [15:0] idx_ext;
  logic [15:0] ent_addr;

  assign idx_ext  = 16'(idx_q);
  assign ent_addr = base_q + (idx_ext << 1);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    base_d      = base_q;
    caddr_d     = caddr_q;
    app_d       = app_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          base_d  = base_addr;
          caddr_d = count_addr;
          app_d   = app_data;
          err_d   = 1'b0;
          state_d = S_RD_CNT;
        end
      end
      S_RD_CNT: begin
        cnt_d = mem_data_out;
        if (!op_q) begin
          if (mem_data_out == 16'd0) begin
            state_d = S_DONE;
          end else if (mem_data_out > MAX_CNT) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d   = '0;
            state_d = S_RD_ENT;
          end
        end else if (mem_data_out >= MAX_CNT) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_WR_ENT;
        end
      end
      S_RD_ENT: begin
        out_data_d  = mem_data_out;
        out_valid_d = 1'b1;
        out_last_d  = (idx_ext == (cnt_q - 16'd1));
        state_d     = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_RD_ENT;
          end
        end
      end
      S_WR_ENT: state_d = S_WR_CNT;
      S_WR_CNT: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Memory port is a pure decode of state; the address is held through WAIT_ACK.
  always_comb begin
    mem_address = 16'd0;
    mem_wr_en   = 1'b0;
    mem_data_in = 16'd0;
    case (state_q)
      S_RD_CNT:             mem_address = caddr_q;
      S_RD_ENT, S_WAIT_ACK: mem_address = ent_addr;
      S_WR_ENT: begin
        mem_address = base_q + (cnt_q << 1);
        mem_wr_en   = 1'b1;
        mem_data_in = app_q;
      end
      S_WR_CNT: begin
        mem_address = caddr_q;
        mem_wr_en   = 1'b1;
        mem_data_in = cnt_q + 16'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      op_q        <= 1'b0;
      base_q      <= 16'd0;
      caddr_q     <= 16'd0;
      app_q       <= 16'd0;
      cnt_q       <= 16'd0;
      idx_q       <= '0;
      out_data_q  <= 16'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      base_q      <= base_d;
      caddr_q     <= caddr_d;
      app_q       <= app_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_mem_list_engine.sv
// tb/tb_mem_list_engine.sv - scoreboard bench for mem_list_engine with byte-level memory and list model
module tb_mem_list_engine;

  logic        clock = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [15:0] base_addr = 16'd0;
  logic [15:0] count_addr = 16'd0;
  logic [15:0] app_data = 16'd0;
  logic        out_ready = 1'b1;
  logic        busy, done, err, out_valid, out_last, mem_wr_en;
  logic [15:0] out_data, mem_address, mem_data_in, mem_data_out;

  mem_list_engine #(.MAX_ENTRIES(64), .IDX_WIDTH(7)) dut (
    .clock(clock), .nrst(nrst), .start(start), .op(op),
    .base_addr(base_addr), .count_addr(count_addr), .app_data(app_data),
    .busy(busy), .done(done), .err(err),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .mem_address(mem_address), .mem_wr_en(mem_wr_en),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clock = ~clock;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  assign mem_data_out = {mem[mem_address], mem[mem_address + 16'd1]};

  always @(posedge clock) begin
    if (mem_wr_en) begin
      mem[mem_address]         <= mem_data_in[15:8];
      mem[mem_address + 16'd1] <= mem_data_in[7:0];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=missing expected=present", name);
  endtask

  // Scoreboard state: expected beats {last,data}, writes {addr,data}, and err per completed op.
  logic [16:0] exp_beats[$];
  logic [31:0] exp_wr[$];
  logic        exp_err[$];
  logic        last_err = 1'b0;
  logic [15:0] addr_log[$];
  int          accept_cyc[$];
  int          first_cyc[$];
  int          ncyc = 0;

  function automatic logic [15:0] rword(input logic [15:0] a);
    return {ref_mem[a], ref_mem[a + 16'd1]};
  endfunction

  task automatic rwrite(input logic [15:0] a, input logic [15:0] d);
    ref_mem[a]         = d[15:8];
    ref_mem[a + 16'd1] = d[7:0];
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    mem[a]             = d[15:8];
    mem[a + 16'd1]     = d[7:0];
    rwrite(a, d);
  endtask

  task automatic model(input bit o, input logic [15:0] b, input logic [15:0] c, input logic [15:0] a);
    int cnt;
    cnt = int'(rword(c));
    if (!o) begin
      if (cnt > 64) begin
        last_err = 1'b1;
      end else begin
        for (int i = 0; i < cnt; i++)
          exp_beats.push_back({(i == cnt - 1), rword(b + 16'(2 * i))});
        last_err = 1'b0;
      end
    end else if (cnt >= 64) begin
      last_err = 1'b1;
    end else begin
      exp_wr.push_back({b + 16'(2 * cnt), a});
      rwrite(b + 16'(2 * cnt), a);
      exp_wr.push_back({c, 16'(cnt + 1)});
      rwrite(c, 16'(cnt + 1));
      last_err = 1'b0;
    end
    exp_err.push_back(last_err);
  endtask

  // Consumer: hold_first stalls the first beat of an op for exactly 5 cycles.
  int stall_cnt = 0;
  bit rand_ready = 1'b0;
  bit hold_first = 1'b0;

  always @(posedge clock) begin
    #1;
    if (hold_first && out_valid) begin
      hold_first = 1'b0;
      stall_cnt  = 5;
    end
    if (stall_cnt > 0) begin
      out_ready = 1'b0;
      stall_cnt--;
    end else begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [15:0] pd = 16'd0, pa = 16'd0;

  always @(negedge clock) begin
    logic [16:0] eb;
    logic [31:0] ew;
    ncyc++;
    if (!nrst) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(pd));
        chk("hold_last", 32'(out_last), 32'(pl));
        chk("hold_addr", 32'(mem_address), 32'(pa));
      end else if (out_valid) begin
        first_cyc.push_back(ncyc);
      end
      if (out_valid && out_ready) begin
        accept_cyc.push_back(ncyc);
        if (exp_beats.size() == 0) begin
          fail_now("beat_unexpected");
        end else begin
          eb = exp_beats.pop_front();
          chk("beat_data", 32'(out_data), 32'(eb[15:0]));
          chk("beat_last", 32'(out_last), 32'(eb[16]));
        end
      end
      if (mem_wr_en) begin
        if (exp_wr.size() == 0) begin
          fail_now("write_unexpected");
        end else begin
          ew = exp_wr.pop_front();
          chk("wr_addr", 32'(mem_address), 32'(ew[31:16]));
          chk("wr_data", 32'(mem_data_in), 32'(ew[15:0]));
        end
      end
      if (busy && !done && mem_address != 16'd0 &&
          (addr_log.size() == 0 || addr_log[$] != mem_address))
        addr_log.push_back(mem_address);
      if (done) begin
        chk("done_busy", 32'(busy), 32'd1);
        if (exp_err.size() == 0) fail_now("done_unexpected");
        else chk("done_err", 32'(err), 32'(exp_err.pop_front()));
        chk("done_beats_left", 32'(exp_beats.size()), 32'd0);
        chk("done_wr_left", 32'(exp_wr.size()), 32'd0);
      end
      if (!busy) begin
        chk("idle_addr", 32'(mem_address), 32'd0);
        chk("idle_wr_en", 32'(mem_wr_en), 32'd0);
        chk("idle_din", 32'(mem_data_in), 32'd0);
        chk("idle_valid", 32'(out_valid), 32'd0);
      end
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last; pa = mem_address;
    end
  end

  task automatic issue(input bit o, input logic [15:0] b, input logic [15:0] c,
                       input logic [15:0] a, input bit use_model);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(posedge clock); #1;
      n++;
    end
    if (busy) fail_now("idle_timeout");
    if (use_model) model(o, b, c, a);
    op = o; base_addr = b; count_addr = c; app_data = a; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    op = 1'($urandom); base_addr = 16'($urandom); count_addr = 16'($urandom); app_data = 16'($urandom);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_err_clear", 32'(err), 32'd0);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 3000) begin
      @(posedge clock); #1;
      n++;
    end
    if (!done) fail_now("done_timeout");
    @(posedge clock); #1;
    chk("post_done_busy", 32'(busy), 32'd0);
    chk("post_done_pulse", 32'(done), 32'd0);
    chk("err_held", 32'(err), 32'(last_err));
  endtask

  initial begin
    int n;
    logic [15:0] exp_seq [3];
    logic [15:0] caddrs [3];
    logic [15:0] bases [3];
    int k;
    exp_seq = '{16'h068A, 16'h01C8, 16'h01CA};
    caddrs  = '{16'h0688, 16'h068A, 16'h0700};
    bases   = '{16'h0008, 16'h01C8, 16'h0300};
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'd0;
      ref_mem[i] = 8'd0;
    end
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_addr", 32'(mem_address), 32'd0);
    repeat (3) @(posedge clock);
    #1 nrst = 1'b1;

    // READ of two entries, consumer always ready
    poke(16'h068A, 16'd2); poke(16'h01C8, 16'd30); poke(16'h01CA, 16'd31);
    addr_log.delete();
    issue(1'b0, 16'h01C8, 16'h068A, 16'h1234, 1'b1);
    wait_done(n);
    chk("rd2_latency", 32'(n), 32'd5);
    chk("rd2_addr_count", 32'(addr_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < addr_log.size(); i++)
      chk("rd2_addr_seq", 32'(addr_log[i]), 32'(exp_seq[i]));

    // Backpressure on beat 0, with a stray start while waiting for acceptance
    accept_cyc.delete(); first_cyc.delete();
    hold_first = 1'b1;
    issue(1'b0, 16'h01C8, 16'h068A, 16'h0000, 1'b1);
    @(posedge clock); #1;
    @(posedge clock); #1;
    op = 1'b1; base_addr = 16'h0400; count_addr = 16'h0688; app_data = 16'hDEAD; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(n);
    chk("bp_beats", 32'(accept_cyc.size()), 32'd2);
    if (accept_cyc.size() >= 2 && first_cyc.size() >= 2) begin
      chk("bp_stall_len", 32'(accept_cyc[0] - first_cyc[0]), 32'd5);
      chk("bp_next_gap", 32'(first_cyc[1] - accept_cyc[0]), 32'd2);
    end

    // APPEND then re-READ
    poke(16'h0688, 16'd1); poke(16'h0008, 16'h0007);
    issue(1'b1, 16'h0008, 16'h0688, 16'h000D, 1'b1);
    wait_done(n);
    chk("app_latency", 32'(n), 32'd3);
    chk("app_count_mem", 32'({mem[16'h0688], mem[16'h0689]}), 32'd2);
    issue(1'b0, 16'h0008, 16'h0688, 16'h0000, 1'b1);
    wait_done(n);

    // Error and empty cases
    poke(16'h0700, 16'd64);
    issue(1'b1, 16'h0300, 16'h0700, 16'h5555, 1'b1);
    wait_done(n);
    chk("app_full_latency", 32'(n), 32'd1);
    poke(16'h0700, 16'd65);
    issue(1'b0, 16'h0300, 16'h0700, 16'h0000, 1'b1);
    wait_done(n);
    chk("rd_over_latency", 32'(n), 32'd1);
    poke(16'h0700, 16'd0);
    issue(1'b0, 16'h0300, 16'h0700, 16'h0000, 1'b1);
    wait_done(n);
    chk("rd_empty_latency", 32'(n), 32'd1);

    // Randomized mix of READ/APPEND with random backpressure
    for (int l = 0; l < 3; l++) begin
      k = $urandom_range(0, 66);
      poke(caddrs[l], 16'(k));
      for (int i = 0; i < 66; i++) poke(bases[l] + 16'(2 * i), 16'($urandom));
    end
    rand_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      k = $urandom_range(0, 2);
      issue(1'($urandom_range(0, 1)), bases[k], caddrs[k], 16'($urandom), 1'b1);
      wait_done(n);
    end
    rand_ready = 1'b0;

    // Reset during WR_ENT: the entry write never commits and the count is untouched
    poke(16'h0688, 16'd5);
    exp_wr.push_back({16'h0012, 16'hBEEF});
    issue(1'b1, 16'h0008, 16'h0688, 16'hBEEF, 1'b0);
    @(posedge clock); #1;
    chk("wrent_wr_en", 32'(mem_wr_en), 32'd1);
    @(negedge clock); #1;
    nrst = 1'b0;
    #1;
    chk("arst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_addr", 32'(mem_address), 32'd0);
    chk("arst_din", 32'(mem_data_in), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    @(posedge clock); @(posedge clock); #1;
    chk("arst_count_mem", 32'({mem[16'h0688], mem[16'h0689]}), 32'd5);
    chk("arst_entry_mem", 32'({mem[16'h0012], mem[16'h0013]}), 32'(rword(16'h0012)));
    chk("arst_wr_left", 32'(exp_wr.size()), 32'd0);
    nrst = 1'b1;
    last_err = 1'b0;
    issue(1'b0, 16'h0008, 16'h0688, 16'h0000, 1'b1);
    wait_done(n);
    chk("end_err_left", 32'(exp_err.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
